add_pipe_acc: RTL and testbench

Parametrised pipelined adder/subtractor/accumulator. It is the successor to the fixed 16-bit two-register adder in the datapath. It adds configurable width and pipeline depth, signed/unsigned arithmetic, subtract and running-accumulate modes, valid/ready flow control and a sticky accumulator-overflow flag. It sits between upstream sample sources and downstream consumers in the processing chain.

---
 rtl/add_pipe_acc_if.sv | 25 ++
 rtl/add_pipe_acc.sv | 91 +++++++++
 tb/tb_add_pipe_acc.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_pipe_acc_if.sv
// Valid/ready operand and result bundle for add_pipe_acc.
// Master drives operands and out_ready; slave returns in_ready, result and the overflow flag.
interface add_pipe_acc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             acc_ovf;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, acc_ovf
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, acc_ovf
    );
endinterface

// File: rtl/add_pipe_acc.sv
// Pipelined add/sub/accumulate/load. Result valid STAGES edges after the accept edge, 1 op/cycle.
// Backpressure: out_valid && !out_ready freezes every stage, ACC and acc_ovf; in_ready = !stall.
module add_pipe_acc #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    add_pipe_acc_if.slave bus
);
    localparam int W1    = WIDTH + 1;
    localparam int DEPTH = STAGES + 1;

    logic [W1-1:0]    r_val [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [W1-1:0]    r_acc;
    logic             r_ovf;

    logic          w_stall;
    logic          w_accept;
    logic [W1-1:0] w_ext_a;
    logic [W1-1:0] w_ext_b;
    logic [W1:0]   w_acc_sum;
    logic          w_wrap;
    logic [W1-1:0] w_stage1;
    logic [W1-1:0] w_acc_nxt;
    logic          w_ovf_nxt;

    assign w_stall  = r_vld[DEPTH-1] && !bus.out_ready;
    assign w_accept = bus.in_valid && !w_stall;

    assign w_ext_a = {((SIGNED != 0) ? bus.a[WIDTH-1] : 1'b0), bus.a};
    assign w_ext_b = {((SIGNED != 0) ? bus.b[WIDTH-1] : 1'b0), bus.b};

    // One extra bit so the unsigned carry out of bit WIDTH is visible.
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_ext_a};
    assign w_wrap    = (SIGNED != 0)
                     ? ((r_acc[W1-1] == w_ext_a[W1-1]) && (w_acc_sum[W1-1] != r_acc[W1-1]))
                     : w_acc_sum[W1];

    always_comb begin
        w_stage1  = '0;
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        case (bus.mode)
            2'b00: w_stage1 = w_ext_a + w_ext_b;
            2'b01: w_stage1 = w_ext_a - w_ext_b;
            2'b10: begin
                w_acc_nxt = w_acc_sum[W1-1:0];
                w_stage1  = w_acc_sum[W1-1:0];
                w_ovf_nxt = r_ovf | w_wrap;
            end
            default: begin
                w_acc_nxt = w_ext_a;
                w_stage1  = w_ext_a;
                w_ovf_nxt = 1'b0;
            end
        endcase
    end

    // Values only move alongside a valid bit, so result holds through bubbles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_val[i] <= '0;
            end
        end else if (!w_stall) begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_val[0] <= w_stage1;
                r_acc    <= w_acc_nxt;
                r_ovf    <= w_ovf_nxt;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_val[i] <= r_val[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = !w_stall;
    assign bus.out_valid = r_vld[DEPTH-1];
    assign bus.result    = r_val[DEPTH-1];
    assign bus.acc_ovf   = r_ovf;
endmodule

// File: tb/tb_add_pipe_acc.sv
// Bench for add_pipe_acc: queue-based reference model checked every cycle plus literal expectations.
module tb_add_pipe_acc;
    localparam int WIDTH  = 16;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_pipe_acc_if #(.WIDTH(WIDTH)) ifc ();
    add_pipe_acc_if #(.WIDTH(WIDTH)) ifs ();

    add_pipe_acc #(.WIDTH(WIDTH), .STAGES(STAGES), .SIGNED(0)) u_dut (
        .clk(clk), .reset_n(rst_n), .bus(ifc.slave)
    );
    add_pipe_acc #(.WIDTH(WIDTH), .STAGES(STAGES), .SIGNED(1)) u_dut_s (
        .clk(clk), .reset_n(rst_n), .bus(ifs.slave)
    );

    typedef struct {
        logic [16:0] val;
        int          adv;
    } ent_t;

    ent_t        q[$];
    logic [16:0] obs[$];
    logic [16:0] obs_s[$];
    logic [16:0] m_acc  = '0;
    logic [16:0] m_last = '0;
    logic        m_ovf  = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    bit          done    = 1'b0;

    bit          ev, stall;
    int          av, bv, s;
    logic [16:0] v, ex, held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted op becomes visible after STAGES unstalled edges past its accept edge.
    always @(negedge clk) begin
        ev = (q.size() > 0) && (q[0].adv >= STAGES);
        ex = ev ? q[0].val : m_last;
        if (mon_en) begin
            check("out_valid", {31'b0, ifc.out_valid}, {31'b0, ev});
            check("result", {15'b0, ifc.result}, {15'b0, ex});
            check("acc_ovf", {31'b0, ifc.acc_ovf}, {31'b0, m_ovf});
            check("in_ready", {31'b0, ifc.in_ready}, {31'b0, !(ev && !ifc.out_ready)});
        end
        if (ifc.out_valid && ifc.out_ready) obs.push_back(ifc.result);
        if (ifs.out_valid && ifs.out_ready) obs_s.push_back(ifs.result);

        stall = ev && !ifc.out_ready;
        if (!rst_n) begin
            q.delete();
            m_acc  = '0;
            m_ovf  = 1'b0;
            m_last = '0;
        end else if (!stall) begin
            if (ev) begin
                m_last = q[0].val;
                void'(q.pop_front());
            end
            foreach (q[i]) q[i].adv = q[i].adv + 1;
            if (ifc.in_valid) begin
                av = {16'b0, ifc.a};
                bv = {16'b0, ifc.b};
                case (ifc.mode)
                    2'd0: v = 17'(av + bv);
                    2'd1: v = 17'(av - bv);
                    2'd2: begin
                        s = {15'b0, m_acc} + av;
                        if (s >= 32'h20000) m_ovf = 1'b1;
                        m_acc = 17'(s);
                        v = m_acc;
                    end
                    default: begin
                        m_acc = 17'(av);
                        m_ovf = 1'b0;
                        v = m_acc;
                    end
                endcase
                q.push_back('{val: v, adv: 0});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit sel, input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        if (sel) begin
            ifs.in_valid = 1'b1; ifs.mode = m; ifs.a = a; ifs.b = b;
        end else begin
            ifc.in_valid = 1'b1; ifc.mode = m; ifc.a = a; ifc.b = b;
        end
        #1;
        while (!(sel ? ifs.in_ready : ifc.in_ready)) begin
            if (k++ > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stuck low at %0t", $time);
                break;
            end
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifs.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.mode = 2'd0; ifc.out_ready = 1'b1;
        ifs.in_valid = 1'b0; ifs.a = '0; ifs.b = '0; ifs.mode = 2'd0; ifs.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("rst_result", {15'b0, ifc.result}, 32'd0);
        check("rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);

        // Add: latency and back-to-back throughput
        obs.delete();
        send(0, 2'b00, 16'hFFFF, 16'h0001);
        send(0, 2'b00, 16'h0001, 16'h0002);
        check("add_lat_early", {31'b0, ifc.out_valid}, 32'd0);
        idle(1);
        check("add_carry_vld", {31'b0, ifc.out_valid}, 32'd1);
        check("add_carry", {15'b0, ifc.result}, 32'h10000);
        idle(1);
        check("add_b2b", {15'b0, ifc.result}, 32'h00003);
        idle(4);

        // Sub with borrow
        obs.delete();
        send(0, 2'b01, 16'h0000, 16'h0001);
        idle(5);
        check("sub_borrow", {15'b0, obs[0]}, 32'h1FFFF);

        // Accumulate stream
        obs.delete();
        send(0, 2'b11, 16'h0005, 16'h0000);
        for (int i = 0; i < 3; i++) send(0, 2'b10, 16'h0003, 16'h0000);
        idle(5);
        check("acc_cnt", obs.size(), 32'd4);
        check("acc_0", {15'b0, obs[0]}, 32'h00005);
        check("acc_1", {15'b0, obs[1]}, 32'h00008);
        check("acc_2", {15'b0, obs[2]}, 32'h0000B);
        check("acc_3", {15'b0, obs[3]}, 32'h0000E);
        check("acc_noovf", {31'b0, ifc.acc_ovf}, 32'd0);

        // Backpressure: 3 stalled cycles in the middle of a stream
        obs.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) send(0, 2'b00, 16'(i), 16'h0000);
            end
            begin
                int k = 0;
                while (!ifc.out_valid && k < 20) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                ifc.out_ready = 1'b0;
                held = ifc.result;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", {31'b0, ifc.in_ready}, 32'd0);
                    check("bp_hold", {15'b0, ifc.result}, {15'b0, held});
                end
                @(posedge clk);
                #1;
                ifc.out_ready = 1'b1;
            end
        join
        idle(6);
        check("bp_cnt", obs.size(), 32'd10);
        for (int i = 0; i < 10 && i < obs.size(); i++) check("bp_order", {15'b0, obs[i]}, i);

        // Overflow: sticky until load
        obs.delete();
        send(0, 2'b11, 16'hFFFF, 16'h0000);
        send(0, 2'b10, 16'hFFFF, 16'h0000);
        check("ovf_before", {31'b0, ifc.acc_ovf}, 32'd0);
        send(0, 2'b10, 16'hFFFF, 16'h0000);
        check("ovf_set", {31'b0, ifc.acc_ovf}, 32'd1);
        send(0, 2'b00, 16'h0001, 16'h0001);
        send(0, 2'b00, 16'h0002, 16'h0002);
        check("ovf_sticky", {31'b0, ifc.acc_ovf}, 32'd1);
        send(0, 2'b11, 16'h0001, 16'h0000);
        check("ovf_clear", {31'b0, ifc.acc_ovf}, 32'd0);
        idle(5);
        check("ovf_cnt", obs.size(), 32'd6);
        check("ovf_r0", {15'b0, obs[0]}, 32'h0FFFF);
        check("ovf_r1", {15'b0, obs[1]}, 32'h1FFFE);
        check("ovf_r2", {15'b0, obs[2]}, 32'h0FFFD);
        check("ovf_r5", {15'b0, obs[5]}, 32'h00001);

        // Signed instance
        send(1, 2'b01, 16'h8000, 16'h0001);
        send(1, 2'b11, 16'h8000, 16'h0000);
        send(1, 2'b10, 16'h8000, 16'h0000);
        check("s_ovf_before", {31'b0, ifs.acc_ovf}, 32'd0);
        send(1, 2'b10, 16'h8000, 16'h0000);
        check("s_ovf_set", {31'b0, ifs.acc_ovf}, 32'd1);
        idle(5);
        check("s_cnt", obs_s.size(), 32'd4);
        check("s_sub", {15'b0, obs_s[0]}, 32'h17FFF);
        check("s_load", {15'b0, obs_s[1]}, 32'h18000);
        check("s_acc1", {15'b0, obs_s[2]}, 32'h10000);
        check("s_acc2", {15'b0, obs_s[3]}, 32'h08000);

        // Reset with ops in flight
        send(0, 2'b11, 16'h1234, 16'h0000);
        send(0, 2'b00, 16'h0001, 16'h0001);
        send(0, 2'b00, 16'h0002, 16'h0002);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mr_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("mr_result", {15'b0, ifc.result}, 32'd0);
        check("mr_acc_ovf", {31'b0, ifc.acc_ovf}, 32'd0);
        obs.delete();
        send(0, 2'b10, 16'h0001, 16'h0000);
        idle(5);
        check("mr_cnt", obs.size(), 32'd1);
        check("mr_acc", {15'b0, obs[0]}, 32'h00001);

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    idle($urandom_range(0, 2));
                    send(0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ifc.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ifc.out_ready = 1'b1;
        idle(8);
        check("drain", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
